mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Sequential signed multiply/divide responder for the multicycle processor.
- The control unit initiates an operation with a one-cycle start pulse. This block iterates, then returns a one-cycle done pulse plus HI/LO results, which the control unit copies into the HI/LO registers.
- Also raises a one-cycle div_zero flag, which the control unit routes to its exception path.

Parameters:
- WIDTH, 32, operand width; also the number of iteration cycles per operation.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- mult_start  input  1  one-cycle pulse: begin signed op_a*op_b.
- div_start  input  1  one-cycle pulse: begin signed op_a/op_b.
- op_a  input  WIDTH  multiplicand / dividend; sampled only on the accepting edge.
- op_b  input  WIDTH  multiplier / divisor; sampled only on the accepting edge.
- busy  output  1  high while an operation is in progress (MULT or DIV state).
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse, coincident with done, when the divisor was zero.
- hi_out  output  WIDTH  mult: product[2W-1:W]; div: remainder.
- lo_out  output  WIDTH  mult: product[W-1:0]; div: quotient.

Behaviour:
- Reset (reset_in=0, asynchronous):
  - state=IDLE, counter=0.
  - busy=0, done=0, div_zero=0, hi_out=0, lo_out=0.
  - All internal datapath registers are cleared.
- Reset mid-operation aborts immediately. No done pulse is produced, and the results are zeroed.
- State machine (one-hot or binary; implementer's choice): IDLE, MULT, DIV, FINISH.
- IDLE:
  - mult_start=1: latch operands, counter=0, go to MULT.
  - div_start=1 with op_b!=0: latch operand magnitudes and signs, go to DIV.
  - div_start=1 with op_b==0: go to FINISH with the dz flag set.
  - Both starts in the same cycle: mult_start wins; div_start is dropped.
- MULT: radix-2 Booth multiplication, one step per cycle.
  - Uses a 2*WIDTH+1-bit accumulator with arithmetic shift right.
  - After WIDTH steps (counter reaches WIDTH-1), go to FINISH.
- DIV: restoring division on magnitudes, one quotient bit per cycle; after WIDTH steps, go to FINISH.
  - Quotient sign = sign(a) XOR sign(b), truncated toward zero.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1: lo=0x80000000, hi=0 (wraps); div_zero stays 0.
- FINISH:
  - Register hi_out/lo_out; pulse done=1 for exactly this one cycle.
  - Return to IDLE next edge.
  - With dz set: div_zero=1, done=1, and hi_out/lo_out keep their previous values.
- Latency, counted as rising edges from the edge that samples the start pulse to the first cycle where done=1:
  - mult: WIDTH+1 (33).
  - div: WIDTH+1 (33).
  - div by zero: 1.
- busy is 1 in MULT and DIV, and 0 in IDLE and FINISH.
- mult_start or div_start while not in IDLE: ignored, with no effect on the running operation or its operands. The control unit must wait for done.
- A new start may be accepted on the edge that leaves FINISH; no dead cycle is required beyond FINISH itself.
- hi_out/lo_out hold their value until the next successful completion.
- op_a/op_b may change freely after the accepting edge.

Optional Feature:
- Macro: MULTDIV_EARLY_OUT_EN.
- Defined: in IDLE, a mult_start with op_a==0 or op_b==0 goes directly to FINISH with a zero result. Likewise, a div_start with op_a==0 (op_b!=0) goes directly to FINISH with hi=lo=0. Latency for these cases is 1. busy never rises for them.
- Not defined: zero operands take the full WIDTH+1 latency, with identical results. Divide-by-zero latency is 1 in both builds.

Test Plan:
- Small signed multiply: mult_start, op_a=7, op_b=0xFFFFFFFD (-3) -> done exactly 33 edges later; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for 32 cycles.
- Large multiply: op_a=op_b=0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001. Also op_a=op_b=0x80000000 -> hi_out=0x40000000, lo_out=0.
- Signed divide: div_start, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF, div_zero=0.
- Overflow divide: op_a=0x80000000, op_b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Divide by zero: first complete 10/3 (lo=3, hi=1), then div_start with op_b=0 -> one edge later done=1 and div_zero=1; hi_out=1 and lo_out=3 are unchanged.
- Protocol corners:
  - div_start at cycle 5 of a running mult, with a different op_a -> ignored; the mult result is correct.
  - mult_start and div_start together -> mult is performed.
  - reset_in low at cycle 10 of a div -> outputs 0 asynchronously and no done pulse. After release, a new mult_start completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit (master) and mult_div_unit (slave).
// state_dbg exposes the unit's FSM state for observation only.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  // Handshake: mult_start/div_start are one-cycle pulses honoured only while the
  // unit is idle or in its finish cycle; op_a/op_b are sampled on that accepting
  // edge only. done is a one-cycle pulse; hi_out/lo_out are valid with it and
  // hold until the next successful completion. div_zero pulses with done.
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [1:0]       state_dbg;

  modport master (
    output mult_start, div_start, op_a, op_b,
    input  busy, done, div_zero, hi_out, lo_out, state_dbg
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output busy, done, div_zero, hi_out, lo_out, state_dbg
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiplier (radix-2 Booth) and divider (restoring, on magnitudes).
// Optional: define MULTDIV_EARLY_OUT_EN to finish zero-operand operations in one cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            reset_in,
  mult_div_unit_if.slave md
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MULT   = 2'd1,
    S_DIV    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] dvsr_q, quo_q, rem_q, quo_d, rem_d;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH:0]   a_ext, m_ext, booth_sum, rem_shift, trial;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last_step;
  logic             mult_zero, div_a_zero;

`ifdef MULTDIV_EARLY_OUT_EN
  assign mult_zero  = (md.op_a == '0) || (md.op_b == '0);
  assign div_a_zero = (md.op_a == '0);
`else
  assign mult_zero  = 1'b0;
  assign div_a_zero = 1'b0;
`endif

  // The Booth add is done one bit wider than A so that subtracting the most
  // negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    a_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    m_ext = {mcand_q[WIDTH-1], mcand_q};
    case (acc_q[1:0])
      2'b01:   booth_sum = a_ext + m_ext;
      2'b10:   booth_sum = a_ext - m_ext;
      default: booth_sum = a_ext;
    endcase
    acc_d = {booth_sum, acc_q[WIDTH:1]};

    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    quo_d     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_d     = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];

    a_mag     = md.op_a[WIDTH-1] ? -md.op_a : md.op_a;
    b_mag     = md.op_b[WIDTH-1] ? -md.op_b : md.op_b;
    last_step = (cnt_q == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      dvsr_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        // FINISH accepts a new start exactly like IDLE, so back-to-back ops need no gap.
        S_IDLE, S_FINISH: begin
          state_q <= S_IDLE;
          if (md.mult_start) begin
            if (mult_zero) begin
              hi_q    <= '0;
              lo_q    <= '0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, md.op_a, 1'b0};
              mcand_q <= md.op_b;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_MULT;
            end
          end else if (md.div_start) begin
            if (md.op_b == '0) begin
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
              state_q    <= S_FINISH;
            end else if (div_a_zero) begin
              hi_q    <= '0;
              lo_q    <= '0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              dvsr_q  <= b_mag;
              q_neg_q <= md.op_a[WIDTH-1] ^ md.op_b[WIDTH-1];
              r_neg_q <= md.op_a[WIDTH-1];
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_DIV;
            end
          end
        end
        S_MULT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            hi_q    <= acc_d[2*WIDTH:WIDTH+1];
            lo_q    <= acc_d[WIDTH:1];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FINISH;
          end
        end
        S_DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            hi_q    <= r_neg_q ? -rem_d : rem_d;
            lo_q    <= q_neg_q ? -quo_d : quo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FINISH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.busy      = busy_q;
  assign md.done      = done_q;
  assign md.div_zero  = div_zero_q;
  assign md.hi_out    = hi_q;
  assign md.lo_out    = lo_q;
  assign md.state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a cycle-level arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk;
  logic reset_in;
  logic chk_en;
  int   total = 0;
  int   bad   = 0;

  mult_div_unit_if #(.WIDTH(W)) md ();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .md       (md)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          rem_edges = 0;
  bit          pending   = 0;
  logic [W-1:0] pend_hi = '0, pend_lo = '0;
  bit          pend_dz = 0;
  logic        exp_busy = 0, exp_done = 0, exp_dz = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  task automatic model_step();
    longint p, qa, qb, q, r;
    if (!reset_in) begin
      rem_edges = 0; pending = 0; pend_dz = 0;
      exp_busy = 0; exp_done = 0; exp_dz = 0; exp_hi = '0; exp_lo = '0;
      return;
    end
    exp_done = 0;
    exp_dz   = 0;
    if (rem_edges > 0) begin
      rem_edges--;
    end else if (md.mult_start || md.div_start) begin
      pending = 1;
      pend_dz = 0;
      if (md.mult_start) begin
        p = longint'($signed(md.op_a)) * longint'($signed(md.op_b));
        pend_hi = p[63:32];
        pend_lo = p[31:0];
        rem_edges = W;
`ifdef MULTDIV_EARLY_OUT_EN
        if (md.op_a == 0 || md.op_b == 0) rem_edges = 0;
`endif
      end else if (md.op_b == 0) begin
        pend_dz = 1;
        rem_edges = 0;
      end else begin
        qa = longint'($signed(md.op_a));
        qb = longint'($signed(md.op_b));
        q  = qa / qb;
        r  = qa % qb;
        pend_lo = q[31:0];
        pend_hi = r[31:0];
        rem_edges = W;
`ifdef MULTDIV_EARLY_OUT_EN
        if (md.op_a == 0) rem_edges = 0;
`endif
      end
    end
    if (pending && rem_edges == 0) begin
      pending  = 0;
      exp_done = 1;
      exp_dz   = pend_dz;
      if (!pend_dz) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end
    exp_busy = (rem_edges > 0);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_in);
      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     32'(md.busy),     32'(exp_busy));
      check("done",     32'(md.done),     32'(exp_done));
      check("div_zero", 32'(md.div_zero), 32'(exp_dz));
      check("hi_out",   md.hi_out,        exp_hi);
      check("lo_out",   md.lo_out,        exp_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input bit now, input bit ms, input bit ds,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    if (!now) begin
      @(posedge clk); #1;
    end
    md.mult_start = ms;
    md.div_start  = ds;
    md.op_a       = a;
    md.op_b       = b;
    @(posedge clk); #1;
    md.mult_start = 1'b0;
    md.div_start  = 1'b0;
    md.op_a       = $urandom;
    md.op_b       = $urandom;
  endtask

  // Called right after the accepting edge; counts that edge as 1.
  task automatic wait_done(input bit junk, output int edges, output int busy_cyc);
    edges = 1;
    busy_cyc = 0;
    while (md.done !== 1'b1 && edges < 100) begin
      if (md.busy === 1'b1) busy_cyc++;
      if (junk && md.busy === 1'b1 && $urandom_range(0, 3) == 0) begin
        md.mult_start = 1'($urandom_range(0, 1));
        md.div_start  = 1'b1;
        md.op_a       = $urandom;
        md.op_b       = $urandom;
      end
      @(posedge clk); #1;
      md.mult_start = 1'b0;
      md.div_start  = 1'b0;
      edges++;
    end
    check("done_seen", 32'(md.done), 32'd1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int edges, bc;
    int kind;
    bit now;
    chk_en        = 1'b0;
    reset_in      = 1'b1;
    md.mult_start = 1'b0;
    md.div_start  = 1'b0;
    md.op_a       = '0;
    md.op_b       = '0;
    #1 reset_in = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(md.busy), 32'd0);
    check("rst_done", 32'(md.done), 32'd0);
    check("rst_hi",   md.hi_out,    32'd0);
    check("rst_lo",   md.lo_out,    32'd0);
    reset_in = 1'b1;

    // small signed multiply
    start_op(0, 1, 0, 32'd7, 32'hFFFF_FFFD);
    wait_done(0, edges, bc);
    check("mul7x-3_lat",  32'(edges), 32'd33);
    check("mul7x-3_busy", 32'(bc),    32'd32);
    check("mul7x-3_hi",   md.hi_out,  32'hFFFF_FFFF);
    check("mul7x-3_lo",   md.lo_out,  32'hFFFF_FFEB);

    // large multiplies
    start_op(0, 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(0, edges, bc);
    check("mulmax_hi", md.hi_out, 32'h3FFF_FFFF);
    check("mulmax_lo", md.lo_out, 32'h0000_0001);
    start_op(0, 1, 0, 32'h8000_0000, 32'h8000_0000);
    wait_done(0, edges, bc);
    check("mulmin_hi", md.hi_out, 32'h4000_0000);
    check("mulmin_lo", md.lo_out, 32'h0000_0000);

    // signed divide
    start_op(0, 0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, edges, bc);
    check("div-7/2_lat", 32'(edges),       32'd33);
    check("div-7/2_lo",  md.lo_out,        32'hFFFF_FFFD);
    check("div-7/2_hi",  md.hi_out,        32'hFFFF_FFFF);
    check("div-7/2_dz",  32'(md.div_zero), 32'd0);

    // overflow divide
    start_op(0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, edges, bc);
    check("divovf_lo", md.lo_out,        32'h8000_0000);
    check("divovf_hi", md.hi_out,        32'h0000_0000);
    check("divovf_dz", 32'(md.div_zero), 32'd0);

    // divide by zero keeps previous results
    start_op(0, 0, 1, 32'd10, 32'd3);
    wait_done(0, edges, bc);
    check("div10/3_lo", md.lo_out, 32'd3);
    check("div10/3_hi", md.hi_out, 32'd1);
    start_op(0, 0, 1, 32'd55, 32'd0);
    wait_done(0, edges, bc);
    check("dz_lat",  32'(edges),       32'd1);
    check("dz_flag", 32'(md.div_zero), 32'd1);
    check("dz_hi",   md.hi_out,        32'd1);
    check("dz_lo",   md.lo_out,        32'd3);

    // div_start during a running mult is ignored
    start_op(0, 1, 0, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    md.div_start = 1'b1;
    md.op_a      = 32'd99;
    md.op_b      = 32'd5;
    @(posedge clk); #1;
    md.div_start = 1'b0;
    wait_done(0, edges, bc);
    check("ignore_hi", md.hi_out, 32'd0);
    check("ignore_lo", md.lo_out, 32'd42);

    // simultaneous starts: mult wins
    start_op(0, 1, 1, 32'd5, 32'd3);
    wait_done(0, edges, bc);
    check("both_lat", 32'(edges), 32'd33);
    check("both_hi",  md.hi_out,  32'd0);
    check("both_lo",  md.lo_out,  32'd15);

    // reset in the middle of a divide
    start_op(0, 0, 1, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset_in = 1'b0;
    #1;
    check("midrst_busy", 32'(md.busy), 32'd0);
    check("midrst_hi",   md.hi_out,    32'd0);
    check("midrst_lo",   md.lo_out,    32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("midrst_done", 32'(md.done), 32'd0);
    end
    reset_in = 1'b1;
    start_op(0, 1, 0, 32'd3, 32'd4);
    wait_done(0, edges, bc);
    check("postrst_lo", md.lo_out, 32'd12);
    check("postrst_hi", md.hi_out, 32'd0);

    // randomized mix, some back-to-back on the finish cycle, some with ignored starts
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      now  = ($urandom_range(0, 2) == 0);
      if (!now) repeat ($urandom_range(0, 3)) @(posedge clk);
      if (!now) #1;
      start_op(1, (kind < 5) || (kind == 9), (kind >= 5), pick_operand(), pick_operand());
      wait_done(1'($urandom_range(0, 1)), edges, bc);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
